ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instruction  input  32  current word from the fetch unit.
REQ-005 zero  input  1  ALU zero flag, combinational from datapath.
REQ-006 ir_write, pc_write  output  1 each  latch instruction / advance PC by 4.
REQ-007 jump, branch  output  1 each  PC-select controls to the fetch unit.
REQ-008 reg_write, reg_dst, alu_src, ext_op, mem_read, mem_write, mem_to_reg  output  1 each  datapath controls.
REQ-009 alu_op  output  4  ALU operation code.
REQ-010 illegal  output  1  undecodable instruction flag.
REQ-011 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-012 The block SHALL be a multicycle MIPS-subset control FSM with Moore outputs decoded from state and an internal 32-bit IR; it decodes only from IR, never from raw `instruction`.
REQ-013 Supported: R-type (op 0x00; funct 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x2A slt), lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, ori 0x0D, lui 0x0F.
REQ-014 States: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
REQ-015 IDLE: all outputs 0; next state is FETCH unconditionally.
REQ-016 FETCH: ir_write=1, pc_write=1; IR loads `instruction` on the exiting edge; next state is DECODE.
REQ-017 DECODE dispatch:
- R-type: EXEC_R.
- addi/ori/lui: EXEC_I.
- lw/sw: MEM_ADDR.
- beq: BRANCH.
- j: JUMP.
- Unsupported opcode or funct: illegal=1 for this cycle only, next state FETCH.
REQ-018 EXEC_R: alu_src=0, alu_op from funct. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-019 EXEC_I: alu_src=1, ext_op=1 for addi else 0, alu_op ADD/OR/LUI. WB_I: reg_write=1, reg_dst=0.
REQ-020 MEM_ADDR: alu_src=1, ext_op=1, alu_op=ADD; goes to MEM_RD (lw) or MEM_WR (sw).
REQ-021 Memory states:
- MEM_RD: mem_read=1, next state MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WR: mem_write=1.
REQ-022 BRANCH: alu_op=SUB, alu_src=0, branch=1, ext_op=1; the fetch unit takes the target when branch&zero; the FSM ignores `zero` for sequencing.
REQ-023 JUMP: jump=1.
REQ-024 WB_R, WB_I, MEM_WB, MEM_WR, BRANCH and JUMP SHALL return to FETCH.
REQ-025 Instruction cycle counts: R/I-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
REQ-026 alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5. addu/subu map to ADD/SUB.
REQ-027 instr_count SHALL increment by 1 on each edge leaving WB_R, WB_I, MEM_WB, MEM_WR, BRANCH or JUMP.
- Illegal instructions are never counted.
- The counter wraps from 2^CNT_W-1 to 0 with no flag.
REQ-028 Outputs not listed for a state SHALL be 0. At most one of jump, branch, mem_read, mem_write SHALL be high in any cycle.

Reset
REQ-029 rst high SHALL immediately force state IDLE, IR 0, instr_count 0 and all outputs 0, regardless of current state, including mid-instruction.
REQ-030 After rst deasserts, the first rising edge moves IDLE to FETCH; an interrupted instruction is never completed or counted.

Structure
REQ-031 Package ctrl_pkg SHALL hold the state enum, opcode/funct constants and alu_op encodings.
REQ-032 A combinational sub-module ctrl_alu_dec (opcode+funct -> alu_op, legal flag) SHALL be instantiated once.
REQ-033 Target size: 150-300 lines of RTL.

Verification
REQ-034 add $3,$1,$2 (0x00221820) -> FETCH, DECODE, EXEC_R (alu_op=0), WB_R (reg_write=1, reg_dst=1); instr_count 0->1 after cycle 4.
REQ-035 lw $2,4($1) (0x8C220004) -> mem_read=1 in cycle 4; reg_write=1, mem_to_reg=1 in cycle 5; FETCH in cycle 6.
REQ-036 beq $1,$2,3 (0x10220003), zero=1 -> branch=1, alu_op=1 in cycle 3; FETCH in cycle 4; count +1.
REQ-037 j 0x0000010 (0x08000010) -> jump=1 in cycle 3. Word 0xFC000000 -> illegal=1 in cycle 2, FETCH in cycle 3, count unchanged.
REQ-038 rst asserted mid-cycle during MEM_RD -> all outputs 0 before the next edge, instr_count=0; after release, FETCH on the first edge.
REQ-039 CNT_W=8: 256 retired add instructions -> instr_count wraps 255->0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, MIPS opcode/funct
// constants and the ALU operation codes driven onto alu_op.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_I,
        WB_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    function automatic logic is_retire_state(input state_t s);
        return (s == WB_R) || (s == WB_I) || (s == MEM_WB) ||
               (s == MEM_WR) || (s == BRANCH) || (s == JUMP);
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Opcode/funct decoder: ALU operation plus a legal flag for the supported subset.
// Purely combinational, no handshake.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_SLT:          alu_op = ALU_SLT;
                    default:         legal  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J: alu_op = ALU_ADD;
            OP_BEQ:                      alu_op = ALU_SUB;
            OP_ORI:                      alu_op = ALU_OR;
            OP_LUI:                      alu_op = ALU_LUI;
            default:                     legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle MIPS-subset control FSM with Moore outputs decoded from state and IR.
// 2-5 cycles per instruction; no backpressure, free-running once out of reset.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic             jump,
    output logic             branch,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             ext_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t      state, next_state;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [3:0]  dec_alu_op;
    logic        dec_legal;

    // The branch outcome is resolved by the fetch unit; sequencing never looks at zero.
    logic unused_sig;
    assign unused_sig = zero ^ (^ir[25:6]);

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    ctrl_alu_dec u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= 32'h0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH)
                ir <= instruction;
            if (is_retire_state(state))
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        next_state = state;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                if (!dec_legal) begin
                    illegal    = 1'b1;
                    next_state = FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:             next_state = EXEC_R;
                        OP_ADDI, OP_ORI,
                        OP_LUI:               next_state = EXEC_I;
                        OP_LW, OP_SW:         next_state = MEM_ADDR;
                        OP_BEQ:               next_state = BRANCH;
                        default:              next_state = JUMP;
                    endcase
                end
            end
            EXEC_R: begin
                alu_op     = dec_alu_op;
                next_state = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                alu_src    = 1'b1;
                ext_op     = (opcode == OP_ADDI);
                alu_op     = dec_alu_op;
                next_state = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                alu_src    = 1'b1;
                ext_op     = 1'b1;
                alu_op     = ALU_ADD;
                next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read   = 1'b1;
                next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                ext_op     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                jump       = 1'b1;
                next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
